// File: rtl/md_bus_resolver.sv
// md_bus_resolver: merges NDRV active-low-enabled drivers into one resolved bus.
// Resolution can be wired-OR, open-drain wired-AND or fixed priority.
// Includes a bus keeper with optional decay to IDLE_VAL when the bus is not driven.
// Also detects contention, with a sticky flag, a saturating counter and first-event capture.
module md_bus_resolver #(
    parameter int             NDRV        = 4,
    parameter int             W           = 16,
    parameter int             MODE        = 0,
    parameter int             HOLD_CYCLES = 0,
    parameter logic [W-1:0]   IDLE_VAL    = '1,
    parameter int             CNT_W       = 16
) (
    input  logic              MCLK,
    input  logic              SRES,
    input  logic [NDRV*W-1:0] drv_o,
    input  logic [NDRV-1:0]   drv_d,
    input  logic              clr,
    output logic [W-1:0]      bus,
    output logic              bus_driven,
    output logic              contention,
    output logic              contention_sticky,
    output logic [CNT_W-1:0]  contention_count,
    output logic [NDRV-1:0]   first_mask,
    output logic [W-1:0]      first_val
);

    // The idle counter only needs to reach HOLD_CYCLES-1; beyond that it just saturates
    localparam int             IW        = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [IW-1:0]  HOLD_LAST = IW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    logic [NDRV-1:0]  enabled;
    logic [W-1:0]     resolved;
    logic [W-1:0]     ref_val;
    logic [W-1:0]     drv_val;
    logic             first_seen;
    logic             differ;

    logic [W-1:0]     keeper_q,     keeper_d;
    logic [IW-1:0]    idle_cnt_q,   idle_cnt_d;
    logic             sticky_q,     sticky_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic [NDRV-1:0]  first_mask_q, first_mask_d;
    logic [W-1:0]     first_val_q,  first_val_d;

    // Resolve the enabled drivers and detect disagreement among them (released drivers are ignored)
    always_comb begin
        enabled    = ~drv_d;
        resolved   = (MODE == 1) ? {W{1'b1}} : {W{1'b0}};
        ref_val    = '0;
        drv_val    = '0;
        first_seen = 1'b0;
        differ     = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (enabled[i]) begin
                drv_val = drv_o[i*W +: W];
                if (MODE == 0) begin
                    resolved = resolved | drv_val;
                end else if (MODE == 1) begin
                    resolved = resolved & drv_val;
                end else if (!first_seen) begin
                    resolved = drv_val;
                end
                if (!first_seen) begin
                    ref_val    = drv_val;
                    first_seen = 1'b1;
                end else if (drv_val != ref_val) begin
                    differ = 1'b1;
                end
            end
        end
        bus_driven = first_seen;
        contention = differ;
        bus        = first_seen ? resolved : keeper_q;
    end

    // Keeper follows the driven bus and decays to IDLE_VAL after HOLD_CYCLES undriven cycles
    always_comb begin
        keeper_d   = keeper_q;
        idle_cnt_d = idle_cnt_q;
        if (bus_driven) begin
            keeper_d   = resolved;
            idle_cnt_d = '0;
        end else begin
            if (idle_cnt_q != {IW{1'b1}}) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if ((HOLD_CYCLES > 0) && (idle_cnt_q == HOLD_LAST)) begin
                keeper_d = IDLE_VAL;
            end
        end
    end

    // Contention statistics; clr beats a same-cycle contention, and capture freezes once sticky
    always_comb begin
        sticky_d     = sticky_q;
        count_d      = count_q;
        first_mask_d = first_mask_q;
        first_val_d  = first_val_q;
        if (clr) begin
            sticky_d     = 1'b0;
            count_d      = '0;
            first_mask_d = '0;
            first_val_d  = '0;
        end else if (contention) begin
            sticky_d = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
            if (!sticky_q) begin
                first_mask_d = enabled;
                first_val_d  = resolved;
            end
        end
    end

    // State registers with synchronous active-low reset taking priority over everything
    always_ff @(posedge MCLK) begin
        if (!SRES) begin
            keeper_q     <= IDLE_VAL;
            idle_cnt_q   <= '0;
            sticky_q     <= 1'b0;
            count_q      <= '0;
            first_mask_q <= '0;
            first_val_q  <= '0;
        end else begin
            keeper_q     <= keeper_d;
            idle_cnt_q   <= idle_cnt_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
            first_mask_q <= first_mask_d;
            first_val_q  <= first_val_d;
        end
    end

    assign contention_sticky = sticky_q;
    assign contention_count  = count_q;
    assign first_mask        = first_mask_q;
    assign first_val         = first_val_q;

endmodule

// File: tb/tb_md_bus_resolver.sv
// tb_md_bus_resolver: directed bench for md_bus_resolver.
// Three instances share stimulus:
//   uOr  - MODE0, HOLD_CYCLES=3, CNT_W=4
//   uAnd - MODE1, HOLD_CYCLES=0, CNT_W=16
//   uPri - MODE2, HOLD_CYCLES=1, CNT_W=16
module tb_md_bus_resolver;

   logic        MCLK;
   logic        SRES;
   logic [63:0] drvO;
   logic [3:0]  drvD;
   logic        clr;

   logic [15:0] orBus, andBus, priBus;
   logic        orDriven, andDriven, priDriven;
   logic        orCont, andCont, priCont;
   logic        orSticky, andSticky, priSticky;
   logic [3:0]  orCount;
   logic [15:0] andCount, priCount;
   logic [3:0]  orMask, andMask, priMask;
   logic [15:0] orFirst, andFirst, priFirst;

   int checks;
   int errors;

   typedef struct {
      logic [3:0]  drvD;
      logic [63:0] drvO;
      logic [15:0] expOr;
      logic [15:0] expAnd;
      logic [15:0] expPri;
      logic        expCont;
   } vec_t;

   vec_t vecs[8];

   md_bus_resolver #(.NDRV(4), .W(16), .MODE(0), .HOLD_CYCLES(3), .IDLE_VAL(16'hFFFF), .CNT_W(4)) uOr (
      .MCLK(MCLK), .SRES(SRES), .drv_o(drvO), .drv_d(drvD), .clr(clr),
      .bus(orBus), .bus_driven(orDriven), .contention(orCont), .contention_sticky(orSticky),
      .contention_count(orCount), .first_mask(orMask), .first_val(orFirst));

   md_bus_resolver #(.NDRV(4), .W(16), .MODE(1), .HOLD_CYCLES(0), .IDLE_VAL(16'hFFFF), .CNT_W(16)) uAnd (
      .MCLK(MCLK), .SRES(SRES), .drv_o(drvO), .drv_d(drvD), .clr(clr),
      .bus(andBus), .bus_driven(andDriven), .contention(andCont), .contention_sticky(andSticky),
      .contention_count(andCount), .first_mask(andMask), .first_val(andFirst));

   md_bus_resolver #(.NDRV(4), .W(16), .MODE(2), .HOLD_CYCLES(1), .IDLE_VAL(16'hFFFF), .CNT_W(16)) uPri (
      .MCLK(MCLK), .SRES(SRES), .drv_o(drvO), .drv_d(drvD), .clr(clr),
      .bus(priBus), .bus_driven(priDriven), .contention(priCont), .contention_sticky(priSticky),
      .contention_count(priCount), .first_mask(priMask), .first_val(priFirst));

   // Free-running 10 ns clock
   initial begin
      MCLK = 1'b0;
      forever #5 MCLK = ~MCLK;
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive the shared inputs; values settle before the caller samples
   task automatic applyStimulus(input logic [3:0] d, input logic [63:0] o, input logic c);
      drvD = d;
      drvO = o;
      clr  = c;
      #1;
   endtask

   // Advance one clock edge and step just past it
   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   // Combinational resolution vectors: {drv_d, {d3,d2,d1,d0}, OR, AND, PRI, contention}
   initial begin
      vecs[0] = '{4'b1010, {16'h2222, 16'h000F, 16'h1111, 16'h00F0}, 16'h00FF, 16'h0000, 16'h00F0, 1'b1};
      vecs[1] = '{4'b1101, {16'h0000, 16'h0000, 16'h1234, 16'h0000}, 16'h1234, 16'h1234, 16'h1234, 1'b0};
      vecs[2] = '{4'b0101, {16'h5555, 16'h0000, 16'hAAAA, 16'h0000}, 16'hFFFF, 16'h0000, 16'hAAAA, 1'b1};
      vecs[3] = '{4'b0101, {16'h5555, 16'h0000, 16'h5555, 16'h0000}, 16'h5555, 16'h5555, 16'h5555, 1'b0};
      vecs[4] = '{4'b1100, {16'h0000, 16'h0000, 16'hFF00, 16'hF0F0}, 16'hFFF0, 16'hF000, 16'hF0F0, 1'b1};
      vecs[5] = '{4'b0000, {16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C}, 16'h3C3C, 16'h3C3C, 16'h3C3C, 1'b0};
      vecs[6] = '{4'b0000, {16'h0008, 16'h0004, 16'h0002, 16'h0001}, 16'h000F, 16'h0000, 16'h0001, 1'b1};
      vecs[7] = '{4'b0111, {16'h8001, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'h8001, 16'h8001, 16'h8001, 1'b0};
   end

   // Main directed sequence
   initial begin
      checks = 0;
      errors = 0;
      SRES   = 1'b0;
      drvD   = 4'hF;
      drvO   = '0;
      clr    = 1'b0;

      // Reset with nothing driving: keeper at idle, stats cleared
      tick();
      tick();
      SRES = 1'b1;
      #1;
      checkOutput("reset_bus_or", orBus, 16'hFFFF);
      checkOutput("reset_bus_and", andBus, 16'hFFFF);
      checkOutput("reset_driven", orDriven, 1'b0);
      checkOutput("reset_cont", orCont, 1'b0);
      checkOutput("reset_sticky", orSticky, 1'b0);
      checkOutput("reset_count", orCount, 4'd0);
      checkOutput("reset_mask", orMask, 4'd0);
      checkOutput("reset_first", orFirst, 16'h0);

      // First contention capture, then a second different contention must not overwrite it
      applyStimulus(4'b1010, {16'h2222, 16'h000F, 16'h1111, 16'h00F0}, 1'b0);
      checkOutput("c2_bus", orBus, 16'h00FF);
      checkOutput("c2_cont", orCont, 1'b1);
      tick();
      checkOutput("c2_sticky", orSticky, 1'b1);
      checkOutput("c2_count", orCount, 4'd1);
      checkOutput("c2_mask", orMask, 4'b0101);
      checkOutput("c2_first", orFirst, 16'h00FF);
      checkOutput("c2_pri_first", priFirst, 16'h00F0);
      applyStimulus(4'b0101, {16'h5555, 16'h0000, 16'hAAAA, 16'h0000}, 1'b0);
      tick();
      checkOutput("c2_count2", orCount, 4'd2);
      checkOutput("c2_mask_frozen", orMask, 4'b0101);
      checkOutput("c2_first_frozen", orFirst, 16'h00FF);

      // Identical drive is not contention and leaves the count alone
      applyStimulus(4'b0101, {16'h5555, 16'h0000, 16'h5555, 16'h0000}, 1'b0);
      tick();
      checkOutput("c4_pri_count_same", priCount, 16'd2);

      // Counter saturation, then clr during contention wins
      applyStimulus(4'b1010, {16'h2222, 16'h000F, 16'h1111, 16'h00F0}, 1'b1);
      tick();
      checkOutput("c5_clr_count", orCount, 4'd0);
      applyStimulus(4'b1010, {16'h2222, 16'h000F, 16'h1111, 16'h00F0}, 1'b0);
      for (int i = 0; i < 20; i++) tick();
      checkOutput("c5_sat_count", orCount, 4'd15);
      checkOutput("c5_pri_count", priCount, 16'd20);
      applyStimulus(4'b1010, {16'h2222, 16'h000F, 16'h1111, 16'h00F0}, 1'b1);
      tick();
      checkOutput("c5_clr_count2", orCount, 4'd0);
      checkOutput("c5_clr_sticky", orSticky, 1'b0);
      checkOutput("c5_clr_mask", orMask, 4'd0);

      // Keeper hold: HOLD 3 on uOr, HOLD 1 on uPri, forever on uAnd
      applyStimulus(4'b1101, {16'h0000, 16'h0000, 16'h1234, 16'h0000}, 1'b0);
      tick();
      applyStimulus(4'b1111, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
      checkOutput("c3_driven", orDriven, 1'b0);
      checkOutput("c3_or_idle1", orBus, 16'h1234);
      checkOutput("c3_pri_idle1", priBus, 16'h1234);
      tick();
      checkOutput("c3_or_idle2", orBus, 16'h1234);
      checkOutput("c3_pri_idle2", priBus, 16'hFFFF);
      tick();
      checkOutput("c3_or_idle3", orBus, 16'h1234);
      tick();
      checkOutput("c3_or_idle4", orBus, 16'hFFFF);
      for (int i = 0; i < 1000; i++) tick();
      checkOutput("c3_and_hold", andBus, 16'h1234);
      checkOutput("c3_or_stays_idle", orBus, 16'hFFFF);

      // Wired-AND contention, then reset while contending
      applyStimulus(4'b1100, {16'h0000, 16'h0000, 16'hFF00, 16'hF0F0}, 1'b0);
      checkOutput("c6_and_bus", andBus, 16'hF000);
      tick();
      checkOutput("c6_and_count", andCount, 16'd1);
      SRES = 1'b0;
      #1;
      checkOutput("c6_bus_in_reset", andBus, 16'hF000);
      checkOutput("c6_cont_in_reset", andCont, 1'b1);
      tick();
      SRES = 1'b1;
      applyStimulus(4'b1111, 64'h0, 1'b0);
      checkOutput("c6_rst_count", andCount, 16'd0);
      checkOutput("c6_rst_sticky", andSticky, 1'b0);
      checkOutput("c6_rst_mask", andMask, 4'd0);
      checkOutput("c6_rst_keeper", andBus, 16'hFFFF);

      // Table of combinational resolution cases across all three modes
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].drvD, vecs[i].drvO, 1'b1);
         checkOutput($sformatf("vec%0d_or", i), orBus, vecs[i].expOr);
         checkOutput($sformatf("vec%0d_and", i), andBus, vecs[i].expAnd);
         checkOutput($sformatf("vec%0d_pri", i), priBus, vecs[i].expPri);
         checkOutput($sformatf("vec%0d_cont", i), priCont, vecs[i].expCont);
         checkOutput($sformatf("vec%0d_driven", i), andDriven, 1'b1);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
